// File: rtl/uart_gpio_cmd.sv
// Byte-command bridge between UART RX/TX cores and board GPIO: LED writes, switch/button
// reads, and debounced button-press event bytes reported to the host.
module uart_gpio_cmd #(
  parameter int NUM_SW          = 4,
  parameter int NUM_BTN         = 2,
  parameter int NUM_LED         = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TIMEOUT_CYCLES  = 10000000,
  parameter int EVENT_EN        = 1
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [7:0]         tx_data,
  input  logic [NUM_SW-1:0]  sw,
  input  logic [NUM_BTN-1:0] btn,
  output logic [NUM_LED-1:0] led,
  output logic               overrun
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_DATA, RESP} state_t;

  state_t             state;
  logic [NUM_SW-1:0]  sw_s1, sw_s2;
  logic [NUM_BTN-1:0] btn_s1, btn_s2, btn_db;
  logic [NUM_BTN-1:0] rise, pending, pending_nxt, evt_mask;
  logic [DB_W-1:0]    db_cnt [NUM_BTN];
  logic [TO_W-1:0]    to_cnt;
  logic [2:0]         evt_idx;
  logic [7:0]         sw_byte, btn_byte;
  logic               evt_take;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= '0;
      btn_s2 <= '0;
    end else begin
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
    end
  end

  // The counter runs only while the synchronised level differs from the accepted one.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      if (!rst_b) begin
        db_cnt[i] <= '0;
        btn_db[i] <= 1'b0;
      end else if (btn_s2[i] == btn_db[i]) begin
        db_cnt[i] <= '0;
      end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_cnt[i] <= '0;
        btn_db[i] <= btn_s2[i];
      end else begin
        db_cnt[i] <= db_cnt[i] + DB_W'(1);
      end
    end
  end

  always_comb begin
    rise     = '0;
    evt_mask = '0;
    evt_idx  = '0;
    sw_byte  = '0;
    btn_byte = '0;
    sw_byte[NUM_SW-1:0]   = sw_s2;
    btn_byte[NUM_BTN-1:0] = btn_db;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      rise[i] = btn_s2[i] && !btn_db[i] && (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1));
    end
    // Descending scan so the lowest pending index is the one left selected.
    for (int unsigned i = NUM_BTN; i > 0; i--) begin
      if (pending[i-1]) begin
        evt_mask      = '0;
        evt_mask[i-1] = 1'b1;
        evt_idx       = 3'(i - 1);
      end
    end
    evt_take    = (state == IDLE) && !rx_valid && (pending != '0);
    pending_nxt = pending & ~(evt_take ? evt_mask : '0);
    if (EVENT_EN != 0) pending_nxt = pending_nxt | rise;
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state    <= IDLE;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      led      <= '0;
      overrun  <= 1'b0;
      pending  <= '0;
      to_cnt   <= '0;
    end else begin
      pending <= pending_nxt;
      case (state)
        IDLE: begin
          if (rx_valid) begin
            case (rx_data)
              8'h57: begin
                state  <= WAIT_DATA;
                to_cnt <= '0;
              end
              8'h52: begin
                tx_data  <= sw_byte;
                tx_valid <= 1'b1;
                state    <= RESP;
              end
              8'h42: begin
                tx_data  <= btn_byte;
                tx_valid <= 1'b1;
                state    <= RESP;
              end
              default: begin
                tx_data  <= 8'h3F;
                tx_valid <= 1'b1;
                state    <= RESP;
              end
            endcase
          end else if (evt_take) begin
            tx_data  <= 8'h30 + {5'b0, evt_idx};
            tx_valid <= 1'b1;
            state    <= RESP;
          end
        end
        WAIT_DATA: begin
          if (rx_valid) begin
            led      <= rx_data[NUM_LED-1:0];
            tx_data  <= 8'h4B;
            tx_valid <= 1'b1;
            state    <= RESP;
          end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            tx_data  <= 8'h3F;
            tx_valid <= 1'b1;
            state    <= RESP;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        RESP: begin
          if (rx_valid) overrun <= 1'b1;
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_gpio_cmd.sv
// Directed bench for uart_gpio_cmd: commands, backpressure, debounce/events, timeout, reset.
module tb_uart_gpio_cmd;

  logic       clk = 1'b0;
  logic       rst_b;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_ready;
  logic [3:0] sw;
  logic [1:0] btn;
  logic       tx_valid, overrun;
  logic [7:0] tx_data;
  logic [3:0] led;
  logic       ne_tx_valid, ne_overrun;
  logic [7:0] ne_tx_data;
  logic [3:0] ne_led;

  int passed = 0;
  int total  = 0;
  int hs_count = 0;

  always #5 clk = ~clk;

  uart_gpio_cmd #(
    .NUM_SW(4), .NUM_BTN(2), .NUM_LED(4),
    .DEBOUNCE_CYCLES(8), .TIMEOUT_CYCLES(16), .EVENT_EN(1)
  ) dut (
    .clk(clk), .rst_b(rst_b), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .sw(sw), .btn(btn), .led(led), .overrun(overrun)
  );

  uart_gpio_cmd #(
    .NUM_SW(4), .NUM_BTN(2), .NUM_LED(4),
    .DEBOUNCE_CYCLES(8), .TIMEOUT_CYCLES(16), .EVENT_EN(0)
  ) dut_ne (
    .clk(clk), .rst_b(rst_b), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(ne_tx_valid), .tx_ready(tx_ready), .tx_data(ne_tx_data),
    .sw(sw), .btn(btn), .led(ne_led), .overrun(ne_overrun)
  );

  always @(posedge clk) if (rst_b && tx_valid && tx_ready) hs_count <= hs_count + 1;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int budget, output logic got);
    got = 1'b0;
    for (int k = 0; k < budget && !got; k++) begin
      step();
      if (tx_valid) got = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_b = 1'b0;
    step(2);
    rst_b = 1'b1;
    total++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); else passed++;
    total++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data got=%h exp=00", tx_data); else passed++;
    total++; if (led !== 4'h0) $display("FAIL reset_led got=%h exp=0", led); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL reset_overrun got=%b exp=0", overrun); else passed++;
  endtask

  task automatic test_write_led;
    int hs0;
    hs0 = hs_count;
    send(8'h57);
    total++; if (tx_valid !== 1'b0) $display("FAIL wled_no_resp_on_w got=%b exp=0", tx_valid); else passed++;
    send(8'h0A);
    total++; if (led !== 4'hA) $display("FAIL wled_led got=%h exp=a", led); else passed++;
    total++; if (tx_valid !== 1'b1 || tx_data !== 8'h4B)
      $display("FAIL wled_ack got=%b/%h exp=1/4b", tx_valid, tx_data); else passed++;
    step(3);
    total++; if (hs_count - hs0 !== 1) $display("FAIL wled_handshakes got=%0d exp=1", hs_count - hs0); else passed++;
  endtask

  task automatic test_read_sw;
    sw = 4'b0110;
    step(3);
    send(8'h52);
    total++; if (tx_valid !== 1'b1 || tx_data !== 8'h06)
      $display("FAIL read_sw got=%b/%h exp=1/06", tx_valid, tx_data); else passed++;
    step();
    send(8'h41);
    total++; if (tx_valid !== 1'b1 || tx_data !== 8'h3F)
      $display("FAIL unknown_cmd got=%b/%h exp=1/3f", tx_valid, tx_data); else passed++;
    step();
  endtask

  task automatic test_debounce;
    logic got, quiet, ne_quiet;
    ne_quiet = 1'b1;
    btn = 2'b10;
    step(5);
    btn = 2'b00;
    quiet = 1'b1;
    for (int k = 0; k < 30; k++) begin
      step();
      if (tx_valid) quiet = 1'b0;
      if (ne_tx_valid) ne_quiet = 1'b0;
    end
    total++; if (quiet !== 1'b1) $display("FAIL glitch_event got=1 exp=0"); else passed++;
    btn = 2'b10;
    wait_tx(40, got);
    total++; if (got !== 1'b1 || tx_data !== 8'h31)
      $display("FAIL press_btn1 got=%b/%h exp=1/31", got, tx_data); else passed++;
    step();
    btn = 2'b00;
    quiet = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (tx_valid) quiet = 1'b0;
      if (ne_tx_valid) ne_quiet = 1'b0;
    end
    total++; if (quiet !== 1'b1) $display("FAIL release_event got=1 exp=0"); else passed++;
    btn = 2'b11;
    wait_tx(40, got);
    total++; if (got !== 1'b1 || tx_data !== 8'h30)
      $display("FAIL dual_first got=%b/%h exp=1/30", got, tx_data); else passed++;
    step();
    wait_tx(5, got);
    total++; if (got !== 1'b1 || tx_data !== 8'h31)
      $display("FAIL dual_second got=%b/%h exp=1/31", got, tx_data); else passed++;
    for (int k = 0; k < 4; k++) begin
      step();
      if (ne_tx_valid) ne_quiet = 1'b0;
    end
    total++; if (ne_quiet !== 1'b1) $display("FAIL event_en0_sent got=1 exp=0"); else passed++;
    send(8'h42);
    total++; if (tx_valid !== 1'b1 || tx_data !== 8'h03)
      $display("FAIL read_btn got=%b/%h exp=1/03", tx_valid, tx_data); else passed++;
    step();
    btn = 2'b00;
    step(20);
  endtask

  task automatic test_timeout;
    logic early;
    send(8'h57);
    early = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (tx_valid) early = 1'b1;
    end
    total++; if (early !== 1'b0) $display("FAIL timeout_early got=1 exp=0"); else passed++;
    step();
    total++; if (tx_valid !== 1'b1 || tx_data !== 8'h3F)
      $display("FAIL timeout_resp got=%b/%h exp=1/3f", tx_valid, tx_data); else passed++;
    total++; if (led !== 4'hA) $display("FAIL timeout_led got=%h exp=a", led); else passed++;
    step();
  endtask

  task automatic test_collision;
    btn = 2'b01;
    send(8'h57);
    step(11);
    total++; if (tx_valid !== 1'b0) $display("FAIL event_held_in_wait got=%b exp=0", tx_valid); else passed++;
    btn = 2'b00;
    send(8'h05);
    total++; if (tx_data !== 8'h4B || led !== 4'h5)
      $display("FAIL coll_write got=%h/%h exp=4b/5", tx_data, led); else passed++;
    step();
    send(8'h52);
    total++; if (tx_valid !== 1'b1 || tx_data !== 8'h06)
      $display("FAIL coll_cmd_first got=%b/%h exp=1/06", tx_valid, tx_data); else passed++;
    step(2);
    total++; if (tx_valid !== 1'b1 || tx_data !== 8'h30)
      $display("FAIL coll_event_second got=%b/%h exp=1/30", tx_valid, tx_data); else passed++;
    step(20);
  endtask

  task automatic test_back_pressure;
    logic stable;
    tx_ready = 1'b0;
    send(8'h52);
    step(3);
    send(8'h42);
    total++; if (overrun !== 1'b1) $display("FAIL overrun_set got=%b exp=1", overrun); else passed++;
    stable = 1'b1;
    for (int k = 0; k < 14; k++) begin
      step();
      if (tx_valid !== 1'b1 || tx_data !== 8'h06) stable = 1'b0;
    end
    total++; if (stable !== 1'b1) $display("FAIL bp_hold got=%b/%h exp=1/06", tx_valid, tx_data); else passed++;
    tx_ready = 1'b1;
    step();
    total++; if (tx_valid !== 1'b0) $display("FAIL bp_release got=%b exp=0", tx_valid); else passed++;
    step(3);
    total++; if (tx_valid !== 1'b0) $display("FAIL dropped_byte_resp got=%b exp=0", tx_valid); else passed++;
    send(8'h52);
    total++; if (tx_valid !== 1'b1 || tx_data !== 8'h06)
      $display("FAIL bp_back_idle got=%b/%h exp=1/06", tx_valid, tx_data); else passed++;
    total++; if (overrun !== 1'b1) $display("FAIL overrun_sticky got=%b exp=1", overrun); else passed++;
    step();
  endtask

  task automatic test_reset_mid_resp;
    logic quiet;
    tx_ready = 1'b0;
    send(8'h52);
    btn = 2'b10;
    step(12);
    btn = 2'b00;
    rst_b = 1'b0;
    step();
    rst_b = 1'b1;
    total++; if (tx_valid !== 1'b0 || led !== 4'h0 || overrun !== 1'b0)
      $display("FAIL mid_reset got=%b/%h/%b exp=0/0/0", tx_valid, led, overrun); else passed++;
    tx_ready = 1'b1;
    quiet = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (tx_valid) quiet = 1'b0;
    end
    total++; if (quiet !== 1'b1) $display("FAIL pending_after_reset got=1 exp=0"); else passed++;
  endtask

  initial begin
    rst_b    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b1;
    sw       = 4'h0;
    btn      = 2'b00;
    @(negedge clk);
    test_reset();
    test_write_led();
    test_read_sw();
    test_debounce();
    test_timeout();
    test_collision();
    test_back_pressure();
    test_reset_mid_resp();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
